// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and sizing for the two-requester memory arbiter
package mem_arb_pkg;
  localparam int NUM_REQ        = 2;
  localparam int BEATS_PER_LINE = 4;
  localparam int BEAT_W         = $clog2(BEATS_PER_LINE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;
endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection for two requesters
// ARB_ROUND_ROBIN_EN: ties go to the requester not granted last; otherwise requester 0 wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic               last_gnt,
`endif
  output logic               winner
);

  always_comb begin
    winner = 1'b0;
    if (req == 2'b10) begin
      winner = 1'b1;
    end
`ifdef ARB_ROUND_ROBIN_EN
    else if (req == 2'b11) begin
      winner = ~last_gnt;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester memory arbiter with grant hold and per-requester beat counters
// ARB_ROUND_ROBIN_EN selects round-robin tie breaking; default build uses fixed priority to requester 0.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_0,
  input  logic              write_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic              read_1,
  input  logic              write_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic [DATA_W-1:0] rdata_0,
  output logic              ready_0,
  output logic              gnt_0,
  output logic [BEAT_W-1:0] beat_0,
  output logic [DATA_W-1:0] rdata_1,
  output logic              ready_1,
  output logic              gnt_1,
  output logic [BEAT_W-1:0] beat_1,
  output logic              read_mem,
  output logic              write_mem,
  output logic [ADDR_W-1:0] addr_mem,
  output logic [DATA_W-1:0] wdata_mem,
  input  logic [DATA_W-1:0] rdata_mem,
  input  logic              ready_mem
);

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] req;
  logic               winner;
  logic               dir_0, dir_1;  // direction seen last edge while granted, 1 = read

  assign req = {read_1 | write_1, read_0 | write_0};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt;

  mem_arb_pick u_pick (
    .req      (req),
    .last_gnt (last_gnt),
    .winner   (winner)
  );
`else
  mem_arb_pick u_pick (
    .req    (req),
    .winner (winner)
  );
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      beat_0 <= '0;
      beat_1 <= '0;
      dir_0  <= 1'b0;
      dir_1  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && |req) begin
        if (winner) begin
          beat_1 <= '0;
          dir_1  <= read_1;
        end else begin
          beat_0 <= '0;
          dir_0  <= read_0;
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_gnt <= winner;
`endif
      end
      // A write-to-read switch under the same grant restarts the line count.
      if (state == GNT0 && req[0]) begin
        if (read_0 != dir_0) begin
          dir_0  <= read_0;
          beat_0 <= '0;
        end else if (ready_0) begin
          beat_0 <= beat_0 + 1'b1;
        end
      end
      if (state == GNT1 && req[1]) begin
        if (read_1 != dir_1) begin
          dir_1  <= read_1;
          beat_1 <= '0;
        end else if (ready_1) begin
          beat_1 <= beat_1 + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req)   state_nxt = winner ? GNT1 : GNT0;
      GNT0:    if (!req[0]) state_nxt = IDLE;
      GNT1:    if (!req[1]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_0     = 1'b0;
    gnt_1     = 1'b0;
    ready_0   = 1'b0;
    ready_1   = 1'b0;
    rdata_0   = '0;
    rdata_1   = '0;
    read_mem  = 1'b0;
    write_mem = 1'b0;
    addr_mem  = '0;
    wdata_mem = '0;
    case (state)
      GNT0: begin
        gnt_0     = 1'b1;
        read_mem  = read_0;
        write_mem = write_0 & ~read_0;
        addr_mem  = addr_0;
        wdata_mem = wdata_0;
        ready_0   = ready_mem & req[0];
        rdata_0   = rdata_mem;
      end
      GNT1: begin
        gnt_1     = 1'b1;
        read_mem  = read_1;
        write_mem = write_1 & ~read_1;
        addr_mem  = addr_1;
        wdata_mem = wdata_1;
        ready_1   = ready_mem & req[1];
        rdata_1   = rdata_mem;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized bench for mem_arbiter against a behavioural model
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        read_0, write_0, read_1, write_1;
  logic [31:0] addr_0, wdata_0, addr_1, wdata_1;
  logic [31:0] rdata_0, rdata_1, addr_mem, wdata_mem, rdata_mem;
  logic        ready_0, ready_1, gnt_0, gnt_1, read_mem, write_mem, ready_mem;
  logic [1:0]  beat_0, beat_1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: current owner (-1 = none), last winner, line beat and direction per requester
  int own;
  bit lg;
  int mbeat[2];
  bit mdir[2];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .read_0(read_0), .write_0(write_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .read_1(read_1), .write_1(write_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .rdata_0(rdata_0), .ready_0(ready_0), .gnt_0(gnt_0), .beat_0(beat_0),
    .rdata_1(rdata_1), .ready_1(ready_1), .gnt_1(gnt_1), .beat_1(beat_1),
    .read_mem(read_mem), .write_mem(write_mem), .addr_mem(addr_mem),
    .wdata_mem(wdata_mem), .rdata_mem(rdata_mem), .ready_mem(ready_mem)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_rd(int x);
    return (x == 1) ? read_1 : read_0;
  endfunction

  function automatic bit m_wr(int x);
    return (x == 1) ? write_1 : write_0;
  endfunction

  function automatic bit m_req(int x);
    return m_rd(x) | m_wr(x);
  endfunction

  task automatic compare_all();
    bit g0, g1;
    g0 = (own == 0);
    g1 = (own == 1);
    check("gnt_0", gnt_0, g0);
    check("gnt_1", gnt_1, g1);
    check("ready_0", ready_0, g0 && ready_mem && m_req(0));
    check("ready_1", ready_1, g1 && ready_mem && m_req(1));
    check("rdata_0", rdata_0, g0 ? rdata_mem : 32'h0);
    check("rdata_1", rdata_1, g1 ? rdata_mem : 32'h0);
    check("beat_0", beat_0, mbeat[0]);
    check("beat_1", beat_1, mbeat[1]);
    check("read_mem", read_mem, (own < 0) ? 1'b0 : m_rd(own));
    check("write_mem", write_mem, (own < 0) ? 1'b0 : (m_wr(own) && !m_rd(own)));
    check("addr_mem", addr_mem, g0 ? addr_0 : g1 ? addr_1 : 32'h0);
    check("wdata_mem", wdata_mem, g0 ? wdata_0 : g1 ? wdata_1 : 32'h0);
  endtask

  task automatic model_step();
    int w;
    if (!reset) begin
      own = -1; lg = 1'b1;
      mbeat[0] = 0; mbeat[1] = 0;
      mdir[0] = 1'b0; mdir[1] = 1'b0;
    end else if (own < 0) begin
      if (m_req(0) || m_req(1)) begin
        if (m_req(0) && m_req(1)) w = RR ? int'(!lg) : 0;
        else w = m_req(1) ? 1 : 0;
        own = w;
        lg = w[0];
        mbeat[w] = 0;
        mdir[w] = m_rd(w);
      end
    end else begin
      w = own;
      if (!m_req(w)) own = -1;
      else if (m_rd(w) != mdir[w]) begin
        mdir[w] = m_rd(w);
        mbeat[w] = 0;
      end else if (ready_mem) mbeat[w] = (mbeat[w] + 1) % 4;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_req();
    read_0 = 0; write_0 = 0; read_1 = 0; write_1 = 0;
  endtask

  initial begin
    own = -1; lg = 1'b1;
    mbeat[0] = 0; mbeat[1] = 0; mdir[0] = 0; mdir[1] = 0;
    reset = 0; clear_req();
    addr_0 = 0; wdata_0 = 0; addr_1 = 0; wdata_1 = 0;
    rdata_mem = 0; ready_mem = 0;

    repeat (4) tick();
    reset = 1;
    tick();
    check("rst_gnt_0", gnt_0, 1'b0);
    check("rst_read_mem", read_mem, 1'b0);

    // Single read stream from requester 0
    read_0 = 1; addr_0 = 32'h0000_4013; ready_mem = 1; rdata_mem = 32'h1111;
    #1 check("lat_gnt_0_pre", gnt_0, 1'b0);
    tick();
    check("lat_gnt_0", gnt_0, 1'b1);
    check("lat_read_mem", read_mem, 1'b1);
    check("lat_addr_mem", addr_mem, 32'h0000_4013);
    check("lat_rdata_0", rdata_0, 32'h1111);
    for (int i = 0; i < 5; i++) begin
      check("beat_0_seq", beat_0, i % 4);
      tick();
    end
    clear_req(); tick();

    // Simultaneous requests and tie breaking
    ready_mem = 0;
    read_0 = 1; read_1 = 1; tick();
    check("tie_first_gnt_0", gnt_0, 1'b1);
    check("tie_first_gnt_1", gnt_1, 1'b0);
    read_0 = 0; tick();
    check("tie_idle_gnt_0", gnt_0, 1'b0);
    check("tie_idle_gnt_1", gnt_1, 1'b0);
    tick();
    check("tie_then_gnt_1", gnt_1, 1'b1);
    read_1 = 0; tick();
    read_0 = 1; tick();
    read_0 = 0; tick();
    read_0 = 1; read_1 = 1; tick();
    check("tie_again_gnt_1", gnt_1, RR);
    check("tie_again_gnt_0", gnt_0, !RR);
    clear_req(); tick();

    // Write stalled by memory, then switch to read without dropping
    write_1 = 1; wdata_1 = 32'h0000_0012; ready_mem = 0; tick();
    check("wr_gnt_1", gnt_1, 1'b1);
    check("wr_write_mem", write_mem, 1'b1);
    check("wr_wdata_mem", wdata_mem, 32'h0000_0012);
    repeat (4) begin
      check("wr_stall_ready_1", ready_1, 1'b0);
      tick();
    end
    ready_mem = 1;
    #1 check("wr_go_ready_1", ready_1, 1'b1);
    tick(); tick();
    check("wr_beat_1", beat_1, 2'd2);
    ready_mem = 0; write_1 = 0; read_1 = 1; tick();
    check("sw_gnt_1", gnt_1, 1'b1);
    check("sw_beat_1", beat_1, 2'd0);
    check("sw_read_mem", read_mem, 1'b1);
    clear_req(); tick();

    // Reset in the middle of a grant
    read_0 = 1; ready_mem = 1; tick();
    check("mid_gnt_0", gnt_0, 1'b1);
    read_1 = 1; reset = 0; tick();
    check("mid_rst_gnt_0", gnt_0, 1'b0);
    check("mid_rst_read_mem", read_mem, 1'b0);
    read_0 = 0; tick();
    check("mid_rst_hold_gnt_1", gnt_1, 1'b0);
    reset = 1; tick();
    check("mid_after_gnt_1", gnt_1, 1'b1);
    clear_req(); tick();

    // Read and write together forward read only
    read_0 = 1; write_0 = 1; tick();
    check("rw_read_mem", read_mem, 1'b1);
    check("rw_write_mem", write_mem, 1'b0);
    clear_req(); tick();

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) read_0  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) write_0 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) read_1  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) write_1 = 1'($urandom_range(0, 1));
      addr_0 = $urandom; addr_1 = $urandom;
      wdata_0 = $urandom; wdata_1 = $urandom;
      rdata_mem = $urandom;
      ready_mem = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 60) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
